capture_stimulus_gen: RTL and testbench

Programmable stimulus generator that drives the timer's control protocol from the other end: it emits the `rst_capture` / `start` / `capture` pulse sequence with exact, programmed cycle spacing, so a timer instance sees known intervals. It sits beside the timer in the test-infrastructure and self-test path. Its pulse outputs connect directly to the timer's `rst_capture_in`, `start_in` and `capture_in` inputs.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/interval_counter.sv | 32 +++
 rtl/capture_stimulus_gen.sv | 172 +++++++++++++++++
 tb/tb_capture_stimulus_gen.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and default widths for the timer and its
//               capture stimulus generator.
// Revision    : 1.0
// ============================================================================
package timer_pkg;

  localparam int c_pulse_w_def = 2;
  localparam int c_cnt_w_def   = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_ARM  = 3'd2,
    ST_WAIT = 3'd3,
    ST_CAP  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/interval_counter.sv
`default_nettype none
// ============================================================================
// Module      : interval_counter
// Description : Loadable down-counter that parks at zero; o_tc flags zero.
// Revision    : 1.0
// ============================================================================
module interval_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule : interval_counter
`default_nettype wire

// File: rtl/capture_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module      : capture_stimulus_gen
// Description : Emits rst_capture / start / N capture pulses with exact,
//               programmed rising-edge spacing for driving a timer.
// Revision    : 1.0
// ============================================================================
module capture_stimulus_gen
  import timer_pkg::*;
#(
  parameter int PULSE_W = c_pulse_w_def,
  parameter int CNT_W   = c_cnt_w_def
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             go_in,
  input  logic             abort_in,
  input  logic [CNT_W-1:0] interval_in,
  input  logic [7:0]       repeat_in,
  output logic             rst_capture_out,
  output logic             start_out,
  output logic             capture_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam logic [CNT_W-1:0] c_pw       = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] c_pw_m1    = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] c_min_ival = CNT_W'(PULSE_W + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_ld;
  logic [7:0]       r_remain;
  logic             r_rst_cap;
  logic             r_start;
  logic             r_cap;
  logic             r_busy;
  logic             r_done;

  logic             w_go;
  logic [CNT_W-1:0] w_ival;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_tc;
  logic             w_cnt_clr;

  assign w_go      = go_in & ~abort_in;
  assign w_ival    = (interval_in < c_min_ival) ? c_min_ival : interval_in;
  assign w_cnt_clr = rst_in | abort_in;

  // Counter holds (cycles remaining in state - 1); it is reloaded on every
  // state change so one instance times both pulse widths and gaps.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        w_load     = w_go;
        w_load_val = c_pw_m1;
      end
      ST_CLR: begin
        w_load     = w_tc;
        w_load_val = c_pw_m1;
      end
      ST_ARM: begin
        w_load     = w_tc && (r_remain != 8'd0);
        w_load_val = r_wait_ld;
      end
      ST_WAIT: begin
        w_load     = w_tc;
        w_load_val = c_pw_m1;
      end
      ST_CAP: begin
        w_load     = w_tc && (r_remain > 8'd1);
        w_load_val = r_wait_ld;
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  interval_counter #(
    .CNT_W (CNT_W)
  ) u_interval_counter (
    .clk        (clk_in),
    .rst        (w_cnt_clr),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in || abort_in) begin
      r_state   <= ST_IDLE;
      r_wait_ld <= '0;
      r_remain  <= '0;
      r_rst_cap <= 1'b0;
      r_start   <= 1'b0;
      r_cap     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            // WAIT lasts I-P cycles, so the counter is loaded with I-P-1.
            r_wait_ld <= w_ival - c_pw - CNT_W'(1);
            r_remain  <= repeat_in;
            r_rst_cap <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ST_CLR;
          end
        end
        ST_CLR: begin
          if (w_tc) begin
            r_rst_cap <= 1'b0;
            r_start   <= 1'b1;
            r_state   <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (w_tc) begin
            r_start <= 1'b0;
            if (r_remain != 8'd0) begin
              r_state <= ST_WAIT;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (w_tc) begin
            r_cap   <= 1'b1;
            r_state <= ST_CAP;
          end
        end
        ST_CAP: begin
          if (w_tc) begin
            r_cap    <= 1'b0;
            r_remain <= r_remain - 8'd1;
            if (r_remain > 8'd1) begin
              r_state <= ST_WAIT;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rst_capture_out = r_rst_cap;
  assign start_out       = r_start;
  assign capture_out     = r_cap;
  assign busy_out        = r_busy;
  assign done_out        = r_done;

endmodule : capture_stimulus_gen
`default_nettype wire

// File: tb/tb_capture_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_stimulus_gen
// Description : Directed self-checking bench for capture_stimulus_gen.
// Revision    : 1.0
// ============================================================================
module tb_capture_stimulus_gen;

  localparam int c_p   = 2;
  localparam int c_cnt = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic             abort;
  logic [c_cnt-1:0] interval;
  logic [7:0]       rep;
  logic             rst_cap;
  logic             start;
  logic             cap;
  logic             busy;
  logic             done;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  capture_stimulus_gen #(
    .PULSE_W (c_p),
    .CNT_W   (c_cnt)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .go_in           (go),
    .abort_in        (abort),
    .interval_in     (interval),
    .repeat_in       (rep),
    .rst_capture_out (rst_cap),
    .start_out       (start),
    .capture_out     (cap),
    .busy_out        (busy),
    .done_out        (done)
  );

  // Vector order: {rst_capture, start, capture, busy, done}
  function automatic logic [4:0] expv(input int c, input int ieff, input int n, input int cut);
    int  d;
    logic rc, st, cp, bz, dn;
    if (c >= cut || c < 1) return 5'b0;
    d  = (n == 0) ? (2 * c_p + 1) : (c_p + 1 + n * ieff + c_p);
    rc = (c >= 1) && (c <= c_p);
    st = (c >= c_p + 1) && (c <= 2 * c_p);
    cp = 1'b0;
    for (int k = 1; k <= n; k++)
      if (c >= c_p + 1 + k * ieff && c < c_p + 1 + k * ieff + c_p) cp = 1'b1;
    bz = (c < d);
    dn = (c == d);
    return {rc, st, cp, bz, dn};
  endfunction

  task automatic check_vec(input string tag, input int c, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // go is sampled at the end of cycle 0; trace[c] is taken mid-cycle c.
  task automatic run(input string tag, input int ival, input int n, input int ieff,
                     input int len, input int go2_c, input int abort_c, input int rst_c,
                     input bit abort_with_go);
    logic [4:0] tr [0:63];
    int cut, st_rise, cap_rise;
    cut = len + 1;
    if (abort_c >= 0) cut = abort_c + 1;
    if (rst_c >= 0)   cut = rst_c + 1;
    if (abort_with_go) cut = 0;
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      tr[c] = {rst_cap, start, cap, busy, done};
      if (c == 0) begin
        interval = ival;
        rep      = 8'(n);
      end
      if (c == 1) begin
        interval = $urandom;
        rep      = 8'($urandom);
      end
      go    = (c == 0) || (c == go2_c);
      abort = (c == abort_c) || (c == 0 && abort_with_go);
      rst   = (c == rst_c);
    end
    go    = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    for (int c = 0; c <= len; c++) check_vec(tag, c, tr[c], expv(c, ieff, n, cut));
    if (n > 0 && cut > len) begin
      st_rise  = -1;
      cap_rise = -1;
      for (int c = 1; c <= len; c++) begin
        if (st_rise < 0 && tr[c][3] && !tr[c-1][3]) st_rise = c;
        if (cap_rise < 0 && tr[c][2] && !tr[c-1][2]) cap_rise = c;
      end
      check_int({tag, "_start_to_capture"}, cap_rise - st_rise, ieff);
    end
  endtask

  initial begin
    rst      = 1'b1;
    go       = 1'b0;
    abort    = 1'b0;
    interval = '0;
    rep      = '0;
    repeat (3) @(negedge clk);
    check_vec("reset", 0, {rst_cap, start, cap, busy, done}, 5'b0);
    rst = 1'b0;
    @(negedge clk);
    check_vec("idle_after_reset", 0, {rst_cap, start, cap, busy, done}, 5'b0);

    run("i10_n1",    10, 1, 10, 20, -1, -1, -1, 1'b0);
    run("i5_n3",      5, 3,  5, 24, -1, -1, -1, 1'b0);
    run("i1_clamp",   1, 2,  3, 14, -1, -1, -1, 1'b0);
    run("n0",         4, 0,  4,  5, -1, -1, -1, 1'b0);
    // Starts in the cycle right after the previous DONE.
    run("rego_i7",    7, 1,  7, 14, -1, -1, -1, 1'b0);
    run("abort9",    10, 1, 10, 20,  6,  9, -1, 1'b0);
    run("rst9",      10, 1, 10, 20,  6, -1,  9, 1'b0);
    run("go_abort",  10, 1, 10, 10, -1, -1, -1, 1'b1);
    run("recover",   10, 1, 10, 16, -1, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_capture_stimulus_gen
`default_nettype wire
